// File: rtl/contact_bounce_gen_pkg.sv
// Shared types and constants for the contact bounce generator.
// Holds the FSM state encoding, the LFSR tap mask and a width helper.
package contact_bounce_gen_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        GLITCH_ON  = 2'b01,
        GLITCH_OFF = 2'b10,
        SETTLE     = 2'b11
    } state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Bits needed to hold 0..value-1; never less than one.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR used as the chatter randomness source.
// An all-zero seed would lock the register, so it is replaced by 1.
module lfsr16
    import contact_bounce_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] seed_safe;

    assign seed_safe = (seed == 16'h0000) ? 16'h0001 : seed;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= seed_safe;
        end else if (value[0]) begin
            value <= (value >> 1) ^ LFSR_TAPS;
        end else begin
            value <= value >> 1;
        end
    end

endmodule

// File: rtl/contact_bounce_gen.sv
// Emulates mechanical switch chatter: each level change gives a random glitch burst then a settle hold.
// Optional statistics ports are built when CONTACT_BOUNCE_GEN_STATS_EN is defined.
module contact_bounce_gen
    import contact_bounce_gen_pkg::*;
#(
    parameter int          CLK_FREQ_HZ = 50_000_000,
    parameter int          SETTLE_MS   = 50,
    parameter int          PHASE_BITS  = 12,
    parameter int          GLITCH_BITS = 3,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        level_in,
    input  logic        bounce_en,
    output logic        sw_out,
    output logic        busy,
    output logic        done_tick
`ifdef CONTACT_BOUNCE_GEN_STATS_EN
    ,
    output logic [15:0] event_count,
    output logic [15:0] glitch_total
`endif
);

    localparam int SETTLE_CYCLES = CLK_FREQ_HZ / 1000 * SETTLE_MS;
    localparam int SETTLE_W      = clog2(SETTLE_CYCLES);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    logic [15:0]            lfsr;
    logic [GLITCH_BITS-1:0] g_rand;
    logic [PHASE_BITS-1:0]  phase_rand;
    logic                   unused_lfsr_bits;

    state_t                 state;
    logic                   target;
    logic                   stable;
    logic [PHASE_BITS-1:0]  phase_cnt;
    logic [GLITCH_BITS-1:0] remaining;
    logic [SETTLE_W-1:0]    settle_cnt;

    lfsr16 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .seed    (SEED),
        .value   (lfsr)
    );

    assign g_rand           = lfsr[GLITCH_BITS-1:0];
    assign phase_rand       = lfsr[PHASE_BITS+GLITCH_BITS-1:GLITCH_BITS];
    assign unused_lfsr_bits = ^lfsr;

    // Outputs are assigned alongside the state change so they track the next state with no extra lag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            target     <= 1'b0;
            stable     <= 1'b0;
            phase_cnt  <= '0;
            remaining  <= '0;
            settle_cnt <= '0;
            sw_out     <= 1'b0;
            busy       <= 1'b0;
            done_tick  <= 1'b0;
        end else begin
            done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (level_in != stable) begin
                        target <= level_in;
                        sw_out <= level_in;
                        busy   <= 1'b1;
                        if (!bounce_en || g_rand == '0) begin
                            settle_cnt <= SETTLE_LOAD;
                            state      <= SETTLE;
                        end else begin
                            remaining <= g_rand;
                            phase_cnt <= phase_rand;
                            state     <= GLITCH_ON;
                        end
                    end
                end
                GLITCH_ON: begin
                    if (phase_cnt == '0) begin
                        phase_cnt <= phase_rand;
                        sw_out    <= ~target;
                        state     <= GLITCH_OFF;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                GLITCH_OFF: begin
                    if (phase_cnt == '0) begin
                        sw_out <= target;
                        if (remaining == GLITCH_BITS'(1)) begin
                            settle_cnt <= SETTLE_LOAD;
                            state      <= SETTLE;
                        end else begin
                            remaining <= remaining - 1'b1;
                            phase_cnt <= phase_rand;
                            state     <= GLITCH_ON;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        stable    <= target;
                        done_tick <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef CONTACT_BOUNCE_GEN_STATS_EN
    logic        start_glitched;
    logic [16:0] glitch_sum;

    assign start_glitched = (state == IDLE) && (level_in != stable) && bounce_en && (g_rand != '0);
    assign glitch_sum     = {1'b0, glitch_total} + 17'(g_rand);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            event_count  <= 16'h0000;
            glitch_total <= 16'h0000;
        end else begin
            if (done_tick) begin
                event_count <= event_count + 16'h0001;
            end
            if (start_glitched) begin
                glitch_total <= glitch_sum[16] ? 16'hFFFF : glitch_sum[15:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_contact_bounce_gen.sv
// Directed self-checking bench for contact_bounce_gen (1 MHz clock, 1 ms settle = 1000 cycles).
// Stats checks are compiled in when CONTACT_BOUNCE_GEN_STATS_EN is defined.
`timescale 1ns/1ps
module tb_contact_bounce_gen;
    import contact_bounce_gen_pkg::*;

    localparam int          SETTLE_CYCLES = 1000;
    localparam logic [15:0] SEED          = 16'h0001;
    localparam int          REC_LEN       = 1300;

    logic clk       = 1'b0;
    logic reset_n   = 1'b0;
    logic level_in  = 1'b0;
    logic bounce_en = 1'b0;
    logic sw_out;
    logic busy;
    logic done_tick;
`ifdef CONTACT_BOUNCE_GEN_STATS_EN
    logic [15:0] event_count;
    logic [15:0] glitch_total;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] m_lfsr;
    logic        sw_rec   [0:REC_LEN-1];
    logic        busy_rec [0:REC_LEN-1];
    logic        done_rec [0:REC_LEN-1];
    logic [15:0] lf_rec   [0:REC_LEN-1];
    logic        exp_sw   [0:REC_LEN-1];

    always #5 clk = ~clk;

    contact_bounce_gen #(
        .CLK_FREQ_HZ (1_000_000),
        .SETTLE_MS   (1),
        .PHASE_BITS  (4),
        .GLITCH_BITS (3),
        .SEED        (SEED)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .level_in  (level_in),
        .bounce_en (bounce_en),
        .sw_out    (sw_out),
        .busy      (busy),
        .done_tick (done_tick)
`ifdef CONTACT_BOUNCE_GEN_STATS_EN
        ,
        .event_count  (event_count),
        .glitch_total (glitch_total)
`endif
    );

    // Reference Galois LFSR, stepped in lockstep with the design's generator.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_lfsr <= SEED;
        else if (m_lfsr[0]) m_lfsr <= {1'b0, m_lfsr[15:1]} ^ 16'hB400;
        else m_lfsr <= {1'b0, m_lfsr[15:1]};
    end

    task automatic run_clean_event(input logic lvl, input string name);
        bit seen;
        seen = 1'b0;
        bounce_en = 1'b0;
        level_in  = lvl;
        for (int n = 0; n < 1200 && !seen; n++) begin
            @(negedge clk);
            if (done_tick === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b1) begin
            bad++;
            $display("FAIL %s_done got=%0b want=1", name, seen);
        end
        total++;
        if (sw_out !== lvl) begin
            bad++;
            $display("FAIL %s_level got=%0b want=%0b", name, sw_out, lvl);
        end
    endtask

    task automatic test_reset;
        int activity;
        reset_n = 1'b0;
        level_in = 1'b0;
        bounce_en = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({sw_out, busy, done_tick} !== 3'b000) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=000", {sw_out, busy, done_tick});
        end
        total++;
        if (dut.state !== IDLE) begin
            bad++;
            $display("FAIL reset_state got=%0d want=%0d", dut.state, IDLE);
        end
        reset_n = 1'b1;
        activity = 0;
        repeat (100) begin
            @(negedge clk);
            if (sw_out !== 1'b0 || busy !== 1'b0 || done_tick !== 1'b0) activity++;
        end
        total++;
        if (activity !== 0) begin
            bad++;
            $display("FAIL idle_activity got=%0d want=0", activity);
        end
    endtask

    task automatic test_clean_edge;
        int busy_cycles, done_cnt, done_at, sw_bad;
        @(negedge clk);
        bounce_en = 1'b0;
        level_in  = 1'b1;
        @(negedge clk);
        total++;
        if (sw_out !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL clean_first_cycle got=%b want=11", {sw_out, busy});
        end
        busy_cycles = 0;
        done_cnt = 0;
        done_at = -1;
        sw_bad = 0;
        for (int i = 0; i < 1100; i++) begin
            if (busy === 1'b1) busy_cycles++;
            if (done_tick === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (sw_out !== 1'b1) sw_bad++;
            @(negedge clk);
        end
        total++;
        if (busy_cycles !== SETTLE_CYCLES) begin
            bad++;
            $display("FAIL clean_busy_len got=%0d want=%0d", busy_cycles, SETTLE_CYCLES);
        end
        total++;
        if (done_cnt !== 1) begin
            bad++;
            $display("FAIL clean_done_count got=%0d want=1", done_cnt);
        end
        total++;
        if (done_at !== SETTLE_CYCLES) begin
            bad++;
            $display("FAIL clean_done_cycle got=%0d want=%0d", done_at, SETTLE_CYCLES);
        end
        total++;
        if (sw_bad !== 0) begin
            bad++;
            $display("FAIL clean_sw_steady got=%0d want=0", sw_bad);
        end
    endtask

    task automatic test_bounce;
        logic [15:0] lf_start, src;
        int g, cur, len, guard, wave_bad, trans, busy_cnt, done_cnt, done_at;
        logic prev;
        bounce_en = 1'b1;
        guard = 0;
        while (m_lfsr[2:0] == 3'd0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        lf_start = m_lfsr;
        level_in = 1'b1;
        for (int i = 0; i < REC_LEN; i++) begin
            @(negedge clk);
            sw_rec[i]   = sw_out;
            busy_rec[i] = busy;
            done_rec[i] = done_tick;
            lf_rec[i]   = m_lfsr;
        end
        // Build the expected waveform: 2g alternating phases, each (slice+1) cycles, then settle.
        g = int'(lf_start[2:0]);
        cur = 0;
        src = lf_start;
        for (int k = 0; k < 2 * g; k++) begin
            len = int'(src[6:3]) + 1;
            for (int j = cur; j < cur + len; j++) exp_sw[j] = (k % 2 == 0);
            src = lf_rec[cur + len - 1];
            cur += len;
        end
        for (int j = cur; j < REC_LEN; j++) exp_sw[j] = 1'b1;
        wave_bad = 0;
        trans = 0;
        busy_cnt = 0;
        done_cnt = 0;
        done_at = -1;
        prev = 1'b0;
        for (int i = 0; i < REC_LEN; i++) begin
            if (sw_rec[i] !== exp_sw[i]) wave_bad++;
            if (sw_rec[i] !== prev) trans++;
            prev = sw_rec[i];
            if (busy_rec[i] === 1'b1) busy_cnt++;
            if (done_rec[i] === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
        end
        total++;
        if (wave_bad !== 0) begin
            bad++;
            $display("FAIL bounce_waveform got=%0d_bad_cycles want=0 (g=%0d)", wave_bad, g);
        end
        total++;
        if (trans !== 2 * g + 1) begin
            bad++;
            $display("FAIL bounce_transitions got=%0d want=%0d", trans, 2 * g + 1);
        end
        total++;
        if (busy_cnt !== cur + SETTLE_CYCLES) begin
            bad++;
            $display("FAIL bounce_busy_len got=%0d want=%0d", busy_cnt, cur + SETTLE_CYCLES);
        end
        total++;
        if (done_cnt !== 1 || done_at !== cur + SETTLE_CYCLES) begin
            bad++;
            $display("FAIL bounce_done got=%0d@%0d want=1@%0d", done_cnt, done_at, cur + SETTLE_CYCLES);
        end
        total++;
        if (sw_out !== 1'b1) begin
            bad++;
            $display("FAIL bounce_final got=%0b want=1", sw_out);
        end
    endtask

    task automatic test_toggle_busy;
        int trans, done_cnt, post;
        bit finished;
        run_clean_event(1'b0, "toggle_prep");
        @(negedge clk);
        bounce_en = 1'b0;
        level_in  = 1'b1;
        @(negedge clk);
        trans = 0;
        done_cnt = 0;
        finished = 1'b0;
        for (int i = 0; i < 1200 && !finished; i++) begin
            if (i == 5) level_in = 1'b0;
            if (i == 8) level_in = 1'b1;
            if (sw_out !== 1'b1) trans++;
            if (done_tick === 1'b1) begin
                done_cnt++;
                finished = 1'b1;
            end
            @(negedge clk);
        end
        post = 0;
        repeat (50) begin
            if (busy !== 1'b0 || done_tick !== 1'b0) post++;
            @(negedge clk);
        end
        total++;
        if (trans !== 0) begin
            bad++;
            $display("FAIL toggle_sw_glitches got=%0d want=0", trans);
        end
        total++;
        if (done_cnt !== 1) begin
            bad++;
            $display("FAIL toggle_done got=%0d want=1", done_cnt);
        end
        total++;
        if (dut.stable !== 1'b1) begin
            bad++;
            $display("FAIL toggle_stable got=%0b want=1", dut.stable);
        end
        total++;
        if (post !== 0) begin
            bad++;
            $display("FAIL toggle_no_new_event got=%0d want=0", post);
        end
    endtask

    task automatic test_reset_mid_event;
        int guard;
        bit seen;
        bounce_en = 1'b1;
        guard = 0;
        while (m_lfsr[2:0] == 3'd0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        level_in = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (dut.state !== GLITCH_OFF && guard < 100);
        total++;
        if (dut.state !== GLITCH_OFF) begin
            bad++;
            $display("FAIL midreset_reach_off got=%0d want=%0d", dut.state, GLITCH_OFF);
        end
        total++;
        if (sw_out !== 1'b1) begin
            bad++;
            $display("FAIL midreset_off_level got=%0b want=1", sw_out);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({sw_out, busy, done_tick} !== 3'b000 || dut.state !== IDLE) begin
            bad++;
            $display("FAIL midreset_async got=%b/%0d want=000/0", {sw_out, busy, done_tick}, dut.state);
        end
        level_in = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (sw_out !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL midreset_restart got=%b want=11", {sw_out, busy});
        end
        seen = 1'b0;
        for (int i = 0; i < REC_LEN && !seen; i++) begin
            @(negedge clk);
            if (done_tick === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b1 || sw_out !== 1'b1) begin
            bad++;
            $display("FAIL midreset_complete got=%0b/%0b want=1/1", seen, sw_out);
        end
    endtask

`ifdef CONTACT_BOUNCE_GEN_STATS_EN
    task automatic test_stats;
        reset_n = 1'b0;
        level_in = 1'b0;
        #3 reset_n = 1'b1;
        @(negedge clk);
        run_clean_event(1'b1, "stats_ev1");
        run_clean_event(1'b0, "stats_ev2");
        run_clean_event(1'b1, "stats_ev3");
        repeat (2) @(negedge clk);
        total++;
        if (event_count !== 16'd3) begin
            bad++;
            $display("FAIL stats_event_count got=%0d want=3", event_count);
        end
        total++;
        if (glitch_total !== 16'd0) begin
            bad++;
            $display("FAIL stats_glitch_total got=%0d want=0", glitch_total);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_edge();
        run_clean_event(1'b0, "return_low");
        test_bounce();
        test_toggle_busy();
        test_reset_mid_event();
`ifdef CONTACT_BOUNCE_GEN_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/contact_bounce_gen.md
# contact_bounce_gen

Generates a deliberately bouncy switch signal from a clean target level, emulating mechanical contact chatter on an edge. It is the source side of the push-button and switch conditioning path: its `sw_out` drives the debouncer's `sw` input on-chip for self-test, or drives a loop-back pin for board-level checks. Each level change produces a pseudo-random burst of glitches, then a settle interval during which the output holds the new level.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 50_000_000: clock frequency in Hz.
- `SETTLE_MS`, 50: settle interval in ms. `SETTLE_CYCLES = CLK_FREQ_HZ/1000*SETTLE_MS`, which must be at least 2.
- `PHASE_BITS`, 12: width of the per-phase random length. A phase lasts 1..2^PHASE_BITS cycles.
- `GLITCH_BITS`, 3: width of the random glitch count. The count is 0..2^GLITCH_BITS-1.
- `SEED`, 16'hACE1: LFSR seed. 16'h0000 is replaced by 16'h0001.

Ports:
- `clk`  in  1  — the single clock.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `level_in`  in  1  — clean target level, synchronous to `clk`.
- `bounce_en`  in  1  — 1 enables glitches; 0 gives clean edges that still include the settle interval.
- `sw_out`  out  1  — emulated switch contact, registered.
- `busy`  out  1  — high while an event is in progress (any state other than IDLE).
- `done_tick`  out  1  — one-cycle pulse when an event completes.

## Operation
- LFSR: 16-bit Galois with taps 16'hB400. It advances every cycle while `reset_n` is high. Its low bits are sampled wherever a random value is loaded.
- The registered `stable` level holds the last settled level.
- FSM states:
  - IDLE: `sw_out = stable`.
  - GLITCH_ON: `sw_out = target`.
  - GLITCH_OFF: `sw_out = ~target`.
  - SETTLE: `sw_out = target`.
- IDLE, when `level_in != stable`:
  - Latch `target = level_in`.
  - Let `g = lfsr[GLITCH_BITS-1:0]`.
  - If `bounce_en` is 0 or `g` is 0: go to SETTLE and load `settle_cnt = SETTLE_CYCLES-1`.
  - Otherwise: load `remaining = g` and `phase_cnt = lfsr[PHASE_BITS+GLITCH_BITS-1:GLITCH_BITS]`, then go to GLITCH_ON.
- GLITCH_ON: decrement `phase_cnt`. When it reaches 0, reload `phase_cnt` from the LFSR and go to GLITCH_OFF.
- GLITCH_OFF: decrement `phase_cnt`. When it reaches 0:
  - If `remaining` is 1: load `settle_cnt` and go to SETTLE.
  - Otherwise: decrement `remaining`, reload `phase_cnt`, and go to GLITCH_ON.
- SETTLE: decrement `settle_cnt`. When it reaches 0: set `stable <= target`, pulse `done_tick`, and go to IDLE.
- `level_in` is ignored outside IDLE. A change that persists is picked up on the first IDLE cycle as a new event. A change that reverts during the event is lost.
- `bounce_en` is sampled only at event start.
- Counters never underflow; the zero check comes before the decrement.

## Timing
- Reset values: all outputs 0, `stable` = 0, state = IDLE, LFSR = `SEED` (zero replaced by 1), all counters 0.
- Edge latency: if `level_in` differs from `stable` at edge t, `sw_out` shows the target at edge t+1 (the first GLITCH_ON cycle or the first SETTLE cycle).
- Durations:
  - Each glitch phase lasts `phase_cnt`+1 cycles.
  - SETTLE lasts exactly `SETTLE_CYCLES` cycles.
  - An event with `g` glitches has exactly `g` ON→OFF pairs, so `sw_out` shows 2g+1 transitions.
- `busy` is high from edge t+1 through the last SETTLE cycle.
- `done_tick` is high during the first IDLE cycle after SETTLE, the same cycle that `busy` falls.
- A new event may start in that same cycle. In that case `busy` rises again one cycle later.
- Reset mid-event: everything returns to reset values immediately and asynchronously. `sw_out` drops to 0, and there is no `done_tick`.

## Configuration
- Macro `CONTACT_BOUNCE_GEN_STATS_EN`:
  - When defined, adds output port `event_count` (16 bits). It increments, wrapping, on each `done_tick`. Reset value is 0.
  - When defined, adds output port `glitch_total` (16 bits). It adds `g` at each glitched event start, saturating at 16'hFFFF. Reset value is 0.
- Without the macro, neither port exists and the counters are not built.

## Structure
- Package `contact_bounce_gen_pkg` holds:
  - the state encodings IDLE=2'b00, GLITCH_ON=2'b01, GLITCH_OFF=2'b10, SETTLE=2'b11;
  - the LFSR tap constant 16'hB400;
  - a clog2 function for sizing `settle_cnt`.
- Sub-module `lfsr16`:
  - ports: `clk`, `reset_n`, `seed[15:0]`, `value[15:0]`;
  - free-running, with seed-zero protection inside.
- The FSM, counters and output register stay in the top module.

## Test plan
- Reset with `CLK_FREQ_HZ`=1_000_000 and `SETTLE_MS`=1: `sw_out`, `busy` and `done_tick` are all 0. Hold `level_in`=0 for 100 cycles → no activity.
- `bounce_en`=0, `level_in` 0→1 at cycle 10 → `sw_out`=1 from cycle 11; `busy` high for cycles 11–1010; `done_tick` at cycle 1011 only.
- `bounce_en`=1 with seed 16'h0001, `level_in` 0→1 → transition count on `sw_out` equals 2g+1, with `g` and each phase length matching the model LFSR; final `sw_out`=1 after exactly 1000 SETTLE cycles.
- Toggle `level_in` 1→0→1 while `busy` is high → no extra transitions; final `stable`=1; no new event after IDLE.
- Assert `reset_n`=0 mid-GLITCH_OFF → `sw_out`, `busy` and `state` are 0 immediately; after release, an event restarts if `level_in`=1.
- With the macro defined, run three events with bounce disabled → `event_count`=3 and `glitch_total`=0.
